// File: rtl/reg_spill_reader.sv
// Walks a wrapping range of register-file addresses through the combinational read port
// and streams {address, data} beats over a valid/ready interface.
module reg_spill_reader #(
  parameter int unsigned AW   = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   beat_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_inc;
  logic [AW-1:0] span;
  logic [AW:0]   remaining;
  logic          accept;
  logic          load;
  logic          drop;
  logic          count;

  assign span    = last_addr - first_addr;
  assign ptr_inc = (ptr == AW'(NREG - 1)) ? '0 : ptr + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    rf_addr    = '0;
    accept     = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    count      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        busy    = 1'b1;
        rf_addr = ptr;
        // abort outranks both the handshake count and a new load
        if (abort) begin
          drop       = 1'b1;
          state_next = IDLE;
        end else begin
          count = out_valid && out_ready;
          load  = (!out_valid || out_ready) && (remaining != '0);
          if (out_valid && out_ready && remaining == '0) begin
            drop       = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = !abort;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      beat_cnt  <= '0;
    end else begin
      if (accept) begin
        ptr       <= first_addr;
        remaining <= {1'b0, span} + (AW+1)'(1);
        beat_cnt  <= '0;
      end
      if (count) beat_cnt <= beat_cnt + (AW+1)'(1);
      if (drop) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
        out_addr  <= ptr;
        out_data  <= rf_data;
        ptr       <= ptr_inc;
        remaining <= remaining - (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_spill_reader.sv
// Directed + randomized bench for reg_spill_reader against a beat-list reference model.
module tb_reg_spill_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] first_addr = '0;
  logic [3:0] last_addr = '0;
  logic [3:0] rf_addr;
  logic [7:0] rf_data;
  logic       out_valid;
  logic [3:0] out_addr;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic [4:0] beat_cnt;

  logic [7:0]  regs [16];
  logic [31:0] cyc = '0;
  int passed = 0;
  int failed = 0;
  int total  = 0;

  reg_spill_reader #(.AW(4), .DW(8), .NREG(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // register 0 behaves like the accumulator: it changes every cycle
  always @(posedge clk) cyc <= cyc + 1;
  assign rf_data = (rf_addr == 4'd0) ? cyc[7:0] : regs[rf_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0,1..., 2 random ready
  task automatic run_spill(input int f, input int l, input int mode, input int abort_beat);
    int n, k, it, a;
    logic [7:0] cur_r0, exp_d;
    bit aborted;
    n = ((l - f + 16) % 16) + 1;
    @(negedge clk);
    start = 1'b1; first_addr = 4'(f); last_addr = 4'(l); out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("fetch_busy", 32'(busy), 32'd1);
    chk("fetch_valid", 32'(out_valid), 32'd0);
    chk("fetch_rf_addr", 32'(rf_addr), 32'(f));
    cur_r0 = cyc[7:0];
    k = 0; it = 0; aborted = 1'b0;
    @(negedge clk);
    chk("first_beat_latency", 32'(out_valid), 32'd1);
    while (k < n && it < 400 && !aborted) begin
      it++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (it % 4 == 1) || (it % 4 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = 1'($urandom_range(0, 1));
      first_addr = 4'($urandom);
      last_addr = 4'($urandom);
      a = (f + k) % 16;
      exp_d = (a == 0) ? cur_r0 : regs[a];
      chk("beat_valid", 32'(out_valid), 32'd1);
      chk("beat_addr", 32'(out_addr), 32'(a));
      chk("beat_data", 32'(out_data), 32'(exp_d));
      chk("beat_cnt_run", 32'(beat_cnt), 32'(k));
      chk("rf_addr_ptr", 32'(rf_addr), 32'((f + k + 1) % 16));
      if (abort_beat == k) begin
        abort = 1'b1;
        aborted = 1'b1;
      end else if (out_ready) begin
        k++;
        cur_r0 = cyc[7:0];
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    if (aborted) begin
      chk_idle_zero("abort_next");
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end else if (k < n) begin
      chk("spill_timeout", 32'(k), 32'(n));
    end else begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_valid", 32'(out_valid), 32'd0);
      chk("done_beat_cnt", 32'(beat_cnt), 32'(n));
      @(negedge clk);
      chk_idle_zero("after_done");
      chk("hold_beat_cnt", 32'(beat_cnt), 32'(n));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'hA0 + 8'(i);
    @(negedge clk);
    chk_idle_zero("reset");
    chk("reset_out_addr", 32'(out_addr), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_beat_cnt", 32'(beat_cnt), 32'd0);
    rst_n = 1'b1;

    run_spill(2, 5, 0, -1);
    run_spill(14, 1, 0, -1);
    run_spill(3, 2, 0, -1);
    run_spill(0, 7, 1, -1);
    run_spill(0, 9, 0, 2);
    run_spill(0, 0, 0, -1);
    run_spill(7, 7, 1, -1);

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", 32'(busy), 32'd0);
    chk("start_abort_idle_valid", 32'(out_valid), 32'd0);

    @(negedge clk);
    start = 1'b1; first_addr = 4'd4; last_addr = 4'd12; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("mid_reset");
    chk("mid_reset_out_addr", 32'(out_addr), 32'd0);
    chk("mid_reset_out_data", 32'(out_data), 32'd0);
    chk("mid_reset_beat_cnt", 32'(beat_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b0;
    run_spill(4, 12, 0, -1);

    for (int r = 0; r < 10; r++) begin
      for (int i = 1; i < 16; i++) regs[i] = 8'($urandom);
      run_spill(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 2,
                (r % 4 == 3) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
